ram_clear_engine: RTL and testbench

Sequencer that owns the initiator side of an 8K×8 single-port work RAM; it drives the RAM's rd/wr/addr/din pins and samples its dout. On a start pulse it fills every location with a byte value and can optionally read back and verify the contents. When idle it passes CPU accesses straight through to the RAM. It sits between the sound/CPU bus decode and the RAM instance and clears the RAM on game reset and on core load.

---
 rtl/ram_clear_engine_if.sv | 46 ++++
 rtl/ram_clear_engine.sv | 115 +++++++++++
 tb/tb_ram_clear_engine.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_clear_engine_if.sv
// Bus bundle for ram_clear_engine: control, CPU pass-through and RAM initiator pins.
// The master side drives control, CPU strobes and RAM read data; the slave side is the engine.
interface ram_clear_engine_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8
);
    logic                  io_start;
    logic [DATA_WIDTH-1:0] io_fillValue;
    logic                  io_verify;
    logic                  io_busy;
    logic                  io_done;
    logic                  io_error;
    logic [ADDR_WIDTH-1:0] io_errorAddr;

    logic                  io_cpu_rd;
    logic                  io_cpu_wr;
    logic [ADDR_WIDTH-1:0] io_cpu_addr;
    logic [DATA_WIDTH-1:0] io_cpu_din;
    logic [DATA_WIDTH-1:0] io_cpu_dout;
    logic                  io_cpu_valid;
    logic                  io_cpu_wait;

    logic                  io_ram_rd;
    logic                  io_ram_wr;
    logic [ADDR_WIDTH-1:0] io_ram_addr;
    logic [DATA_WIDTH-1:0] io_ram_din;
    logic [DATA_WIDTH-1:0] io_ram_dout;

    modport master (
        output io_start, io_fillValue, io_verify,
        output io_cpu_rd, io_cpu_wr, io_cpu_addr, io_cpu_din,
        output io_ram_dout,
        input  io_busy, io_done, io_error, io_errorAddr,
        input  io_cpu_dout, io_cpu_valid, io_cpu_wait,
        input  io_ram_rd, io_ram_wr, io_ram_addr, io_ram_din
    );

    modport slave (
        input  io_start, io_fillValue, io_verify,
        input  io_cpu_rd, io_cpu_wr, io_cpu_addr, io_cpu_din,
        input  io_ram_dout,
        output io_busy, io_done, io_error, io_errorAddr,
        output io_cpu_dout, io_cpu_valid, io_cpu_wait,
        output io_ram_rd, io_ram_wr, io_ram_addr, io_ram_din
    );
endinterface

// File: rtl/ram_clear_engine.sv
// Work-RAM fill/verify sequencer with idle-time CPU pass-through.
// Owns the RAM initiator pins; clears the RAM on game reset and core load.
module ram_clear_engine #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    ram_clear_engine_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        FILL,
        VERIFY,
        DRAIN,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] err_addr;
    logic [DATA_WIDTH-1:0] fill_q;
    logic                  verify_q;
    logic                  err_q;
    logic                  rd_pend;
    logic                  cpu_valid_q;

    logic is_idle;
    logic in_fill;
    logic in_verify;
    logic busy;
    logic fwd;
    logic fwd_wr;
    logic fwd_rd;
    logic mism;
    logic last;

    always_comb begin
        is_idle   = (state == IDLE);
        in_fill   = (state == FILL);
        in_verify = (state == VERIFY);
        busy      = in_fill || in_verify || (state == DRAIN);
        last      = &cnt;
        // A start in IDLE pre-empts any CPU strobe in the same cycle
        fwd       = is_idle && !bus.io_start && !reset;
        fwd_wr    = fwd && bus.io_cpu_wr;
        fwd_rd    = fwd && bus.io_cpu_rd && !bus.io_cpu_wr;
        mism      = rd_pend && (bus.io_ram_dout != fill_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rd_addr     <= '0;
            err_addr    <= '0;
            fill_q      <= '0;
            verify_q    <= 1'b0;
            err_q       <= 1'b0;
            rd_pend     <= 1'b0;
            cpu_valid_q <= 1'b0;
        end else begin
            cpu_valid_q <= fwd_rd;
            rd_pend     <= in_verify;
            rd_addr     <= cnt;
            // Only the first mismatch address is kept
            if (mism && !err_q) begin
                err_q    <= 1'b1;
                err_addr <= rd_addr;
            end
            unique case (state)
                IDLE: begin
                    if (bus.io_start) begin
                        fill_q   <= bus.io_fillValue;
                        verify_q <= bus.io_verify;
                        err_q    <= 1'b0;
                        err_addr <= '0;
                        cnt      <= '0;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= verify_q ? VERIFY : DONE;
                    end
                end
                VERIFY: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: state <= DONE;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.io_busy      = busy;
        bus.io_done      = (state == DONE);
        bus.io_error     = err_q;
        bus.io_errorAddr = err_addr;
        bus.io_cpu_dout  = bus.io_ram_dout;
        bus.io_cpu_valid = cpu_valid_q;
        bus.io_cpu_wait  = busy || (is_idle && bus.io_start);
        bus.io_ram_wr    = !reset && (in_fill || fwd_wr);
        bus.io_ram_rd    = !reset && (in_verify || fwd_rd);
        bus.io_ram_addr  = (in_fill || in_verify) ? cnt : bus.io_cpu_addr;
        bus.io_ram_din   = in_fill ? fill_q : bus.io_cpu_din;
    end
endmodule

// File: tb/tb_ram_clear_engine.sv
// Scoreboard bench for ram_clear_engine with an 8Kx8 RAM model.
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_ram_clear_engine;
    localparam int AW = 13;
    localparam int DW = 8;
    localparam int N  = 1 << AW;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ram_clear_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    ram_clear_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    logic [DW-1:0] mem     [N];
    logic [DW-1:0] ref_mem [N];
    logic [DW-1:0] dout_r = '0;
    bit            inject = 1'b0;
    logic [AW-1:0] inj_addrs [$];

    typedef struct {
        int            cyc;
        bit            err;
        logic [AW-1:0] eaddr;
        bit            ver;
    } done_t;

    done_t         exp_done [$];
    logic [DW-1:0] exp_cpu  [$];

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            op_start = 0;
    int            wr_n = 0;
    int            rd_n = 0;
    int            done_cnt = 0;
    logic [DW-1:0] op_fill = '0;

    function automatic bit is_inj(input logic [AW-1:0] a);
        foreach (inj_addrs[i]) if (inj_addrs[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.io_ram_wr) mem[bus.io_ram_addr] <= bus.io_ram_din;
        if (bus.io_ram_rd)
            dout_r <= (inject && bus.io_busy && is_inj(bus.io_ram_addr))
                      ? 8'hFF : mem[bus.io_ram_addr];
    end
    assign bus.io_ram_dout = dout_r;

    task automatic chk(input bit ok, input string name,
                       input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: strobe ordering, CPU read data and DONE results
    always @(negedge clock) begin
        int    rel;
        done_t d;
        logic [DW-1:0] e;
        rel = cyc - op_start;
        if (!reset) begin
            if (bus.io_busy && bus.io_ram_wr) begin
                chk(bus.io_ram_addr == AW'(wr_n), "fill_addr", bus.io_ram_addr, wr_n);
                chk(bus.io_ram_din == op_fill, "fill_data", bus.io_ram_din, op_fill);
                chk(rel == wr_n + 1, "fill_cycle", rel, wr_n + 1);
                wr_n++;
            end
            if (bus.io_busy && bus.io_ram_rd) begin
                chk(bus.io_ram_addr == AW'(rd_n), "verify_addr", bus.io_ram_addr, rd_n);
                chk(rel == N + 1 + rd_n, "verify_cycle", rel, N + 1 + rd_n);
                rd_n++;
            end
            if (bus.io_cpu_valid) begin
                chk(exp_cpu.size() != 0, "cpu_valid_unexpected", 1, 0);
                if (exp_cpu.size() != 0) begin
                    e = exp_cpu.pop_front();
                    chk(bus.io_cpu_dout == e, "cpu_rdata", bus.io_cpu_dout, e);
                end
            end
            if (bus.io_done) begin
                done_cnt++;
                chk(exp_done.size() != 0, "done_unexpected", 1, 0);
                if (exp_done.size() != 0) begin
                    d = exp_done.pop_front();
                    chk(rel == d.cyc, "done_cycle", rel, d.cyc);
                    chk(bus.io_error == d.err, "done_error", bus.io_error, d.err);
                    if (d.err)
                        chk(bus.io_errorAddr == d.eaddr, "error_addr",
                            bus.io_errorAddr, d.eaddr);
                    chk(wr_n == N, "fill_count", wr_n, N);
                    chk(rd_n == (d.ver ? N : 0), "verify_count", rd_n, d.ver ? N : 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_op(input logic [DW-1:0] f, input bit ver, input bit collide);
        done_t         d;
        logic [AW-1:0] m;
        bus.io_start     = 1'b1;
        bus.io_fillValue = f;
        bus.io_verify    = ver;
        if (collide) begin
            bus.io_cpu_wr   = 1'b1;
            bus.io_cpu_rd   = 1'b1;
            bus.io_cpu_addr = 13'd5;
            bus.io_cpu_din  = ~f;
        end
        #1;
        chk(bus.io_cpu_wait == 1'b1, "wait_on_start", bus.io_cpu_wait, 1);
        if (collide)
            chk(!bus.io_ram_wr && !bus.io_ram_rd, "start_wins",
                {bus.io_ram_wr, bus.io_ram_rd}, 0);
        op_start = cyc;
        wr_n     = 0;
        rd_n     = 0;
        op_fill  = f;
        m = {AW{1'b1}};
        foreach (inj_addrs[i]) if (inj_addrs[i] < m) m = inj_addrs[i];
        d.cyc   = ver ? 2 * N + 2 : N + 1;
        d.err   = ver && inject && (f != 8'hFF) && (inj_addrs.size() != 0);
        d.eaddr = m;
        d.ver   = ver;
        exp_done.push_back(d);
        tick();
        bus.io_start  = 1'b0;
        bus.io_cpu_wr = 1'b0;
        bus.io_cpu_rd = 1'b0;
        chk(bus.io_error == 1'b0, "error_cleared", bus.io_error, 0);
        chk(bus.io_busy == 1'b1, "busy_cycle1", bus.io_busy, 1);
    endtask

    task automatic wait_done(input int bound);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < bound) begin
            tick();
            n++;
        end
        chk(done_cnt != d0, "done_timeout", n, bound);
        tick();
        for (int i = 0; i < N; i++) ref_mem[i] = op_fill;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] v, input bit also_rd);
        bus.io_cpu_wr   = 1'b1;
        bus.io_cpu_rd   = also_rd;
        bus.io_cpu_addr = a;
        bus.io_cpu_din  = v;
        ref_mem[a]      = v;
        tick();
        bus.io_cpu_wr = 1'b0;
        bus.io_cpu_rd = 1'b0;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a);
        bus.io_cpu_rd   = 1'b1;
        bus.io_cpu_addr = a;
        exp_cpu.push_back(ref_mem[a]);
        tick();
        bus.io_cpu_rd = 1'b0;
    endtask

    task automatic mem_check(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk(bad == 0, name, bad, 0);
    endtask

    initial begin
        logic [DW-1:0] f;
        logic [AW-1:0] a;
        int            dc;
        for (int i = 0; i < N; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        inj_addrs.push_back(13'h1300);
        inj_addrs.push_back(13'h1234);
        bus.io_start     = 1'b0;
        bus.io_fillValue = '0;
        bus.io_verify    = 1'b0;
        bus.io_cpu_rd    = 1'b0;
        bus.io_cpu_wr    = 1'b1;
        bus.io_cpu_addr  = 13'd7;
        bus.io_cpu_din   = 8'h11;

        // Reset with a CPU write pending: nothing may reach the RAM
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk(bus.io_ram_wr == 1'b0, "reset_no_wr", bus.io_ram_wr, 0);
        chk(bus.io_ram_rd == 1'b0, "reset_no_rd", bus.io_ram_rd, 0);
        chk(bus.io_busy == 1'b0, "reset_busy", bus.io_busy, 0);
        chk(bus.io_done == 1'b0, "reset_done", bus.io_done, 0);
        chk(bus.io_error == 1'b0, "reset_error", bus.io_error, 0);
        chk(bus.io_errorAddr == '0, "reset_erraddr", bus.io_errorAddr, 0);
        chk(bus.io_cpu_valid == 1'b0, "reset_valid", bus.io_cpu_valid, 0);
        @(posedge clock);
        #1;
        reset         = 1'b0;
        bus.io_cpu_wr = 1'b0;
        tick();
        mem_check("mem_after_reset");

        start_op(8'hA5, 1'b0, 1'b0);
        wait_done(N + 10);
        mem_check("mem_fill_a5");

        cpu_write(13'h0010, 8'h5A, 1'b0);
        cpu_read(13'h0010);
        cpu_write(13'h0020, 8'h77, 1'b1);
        cpu_read(13'h0020);
        repeat (40) begin
            a = 13'($urandom_range(0, 63));
            f = 8'($urandom);
            case ($urandom_range(0, 2))
                0: cpu_write(a, f, 1'b0);
                1: cpu_read(a);
                default: cpu_write(a, f, 1'b1);
            endcase
        end
        for (int i = 0; i < 8; i++) cpu_read(13'(i * 3));
        tick();
        tick();
        chk(exp_cpu.size() == 0, "cpu_reads_drained", exp_cpu.size(), 0);
        mem_check("mem_cpu");

        start_op(8'h3C, 1'b1, 1'b1);
        wait_done(2 * N + 10);
        mem_check("mem_fill_3c");

        inject = 1'b1;
        f = 8'($urandom_range(0, 254));
        start_op(f, 1'b1, 1'b0);
        wait_done(2 * N + 10);
        inject = 1'b0;
        chk(bus.io_error == 1'b1, "error_sticky", bus.io_error, 1);

        // Busy window: CPU traffic and a second start must be ignored
        f = 8'($urandom);
        dc = done_cnt;
        start_op(f, 1'b0, 1'b0);
        repeat (99) tick();
        bus.io_cpu_wr   = 1'b1;
        bus.io_cpu_addr = 13'd0;
        bus.io_cpu_din  = ~f;
        #1;
        chk(bus.io_cpu_wait == 1'b1, "wait_busy", bus.io_cpu_wait, 1);
        tick();
        bus.io_cpu_wr = 1'b0;
        repeat (49) tick();
        bus.io_cpu_rd   = 1'b1;
        bus.io_cpu_addr = 13'd0;
        tick();
        bus.io_cpu_rd = 1'b0;
        repeat (49) tick();
        bus.io_start     = 1'b1;
        bus.io_fillValue = ~f;
        bus.io_verify    = 1'b1;
        tick();
        bus.io_start = 1'b0;
        wait_done(N + 10);
        repeat (20) tick();
        chk(done_cnt == dc + 1, "done_once", done_cnt - dc, 1);
        mem_check("mem_busy_fill");

        // Reset in cycle 4000 of a fill
        f = ~op_fill;
        start_op(f, 1'b0, 1'b0);
        repeat (3999) tick();
        reset = 1'b1;
        void'(exp_done.pop_back());
        @(negedge clock);
        chk(!bus.io_ram_wr && !bus.io_ram_rd, "midreset_no_strobe",
            {bus.io_ram_wr, bus.io_ram_rd}, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk(bus.io_busy == 1'b0, "midreset_busy", bus.io_busy, 0);
        chk(!bus.io_ram_wr && !bus.io_ram_rd, "midreset_idle_strobe",
            {bus.io_ram_wr, bus.io_ram_rd}, 0);
        for (int i = 0; i < 3999; i++) ref_mem[i] = f;
        repeat (30) tick();
        mem_check("mem_partial_fill");
        start_op(8'($urandom), 1'b0, 1'b0);
        wait_done(N + 10);
        mem_check("mem_restart");

        repeat (5) tick();
        chk(exp_done.size() == 0, "done_pending", exp_done.size(), 0);
        chk(exp_cpu.size() == 0, "cpu_pending", exp_cpu.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
